spi_slave_port: RTL

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

---
 rtl/spi_slave_port.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - SPI mode-0 slave with tx holding register and sticky status
//
// Ports:
//   clk_clk, reset_reset_n     system clock, async active-low reset
//   spi_SCLK/SS_n/MOSI/MISO    SPI mode 0 (CPOL=0, CPHA=0), MSB first
//   rx_data, rx_valid          last complete frame, one-cycle update pulse
//   tx_data, tx_valid/tx_ready next frame to send, holding-register handshake
//   busy                       frame in progress
//   tx_underrun, frame_err     sticky status, cleared by status_clr
module spi_slave_port #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              spi_SCLK,
    input  logic              spi_SS_n,
    input  logic              spi_MOSI,
    output logic              spi_MISO,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              tx_underrun,
    output logic              frame_err,
    input  logic              status_clr
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SHIFT      = 2'd1;
    localparam logic [1:0] ST_WAIT_DESEL = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   armed_q;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              frame_err_q, frame_err_d;
    logic              pend_q, pend_d;

    logic              sclk_s, ss_s, mosi_s;
    logic              sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic              load, set_ur, set_fe;
    logic [DATA_W-1:0] rx_next;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign rx_next   = {rx_shift_q[DATA_W-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        pend_d      = pend_q;
        load        = 1'b0;
        set_ur      = 1'b0;
        set_fe      = 1'b0;

        case (state_q)
            // The synchronizer resets to "deselected", so a reset released
            // mid-frame would look like SS_n high. armed_q delays the check
            // until the whole chain holds real input samples.
            ST_WAIT_DESEL: begin
                if (armed_q && (&ss_sync_q) && ss_prev_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_q != '0 && bit_cnt_q != CNT_FULL) begin
                        set_fe = 1'b1;
                    end
                end else if (sclk_rise) begin
                    // An empty-load only counts as underrun once the master
                    // actually clocks the frame; the reload after the last
                    // falling edge of a transfer is otherwise harmless.
                    if (bit_cnt_q == '0 && pend_q) begin
                        set_ur = 1'b1;
                        pend_d = 1'b0;
                    end
                    rx_shift_d = rx_next;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_LAST) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        load      = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b1};
                    end
                end
            end
            default: state_d = ST_WAIT_DESEL;
        endcase

        // Accept and load never both touch hold_full: accept needs it clear,
        // a consuming load needs it set.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (load) begin
            pend_d = !hold_full_q;
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = '1;
            end
        end

        underrun_d  = set_ur ? 1'b1 : (status_clr ? 1'b0 : underrun_q);
        frame_err_d = set_fe ? 1'b1 : (status_clr ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= ST_WAIT_DESEL;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '1;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_SCLK};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_SS_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_MOSI};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            armed_q     <= 1'b1;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            pend_q      <= pend_d;
        end
    end

    assign busy        = (state_q == ST_SHIFT);
    assign spi_MISO    = busy ? tx_shift_q[DATA_W-1] : 1'b1;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;

endmodule
